sramx_rr_arbiter: RTL and testbench
===================================

# sramx_rr_arbiter

Parametrised N-channel arbiter that merges several SRAMx-style requesters (converted instruction/data buses, future DMA or debug masters) onto one SRAM port with fixed one-cycle read latency. It replaces point-to-point core-to-SRAM wiring at the SoC top level. It provides round-robin fairness, pipelined issue of one request per cycle, response routing back to the issuing channel, and optional MIPS kseg0/kseg1 address translation.

## Interface
- NUM_CH, 2, number of requester channels (1..8)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; byte-enable width WB = DATA_WIDTH/8
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- ch_req  in  NUM_CH  per-channel request valid; held until its ch_addr_ok
- ch_wen  in  NUM_CH×WB  per-channel byte write enables; all-zero means read
- ch_addr  in  NUM_CH×ADDR_WIDTH  per-channel virtual byte address
- ch_wdata  in  NUM_CH×DATA_WIDTH  per-channel write data
- ch_addr_ok  out  NUM_CH  one-hot or zero; request accepted this cycle
- ch_data_ok  out  NUM_CH  one-hot or zero; response for the accepted request
- ch_rdata  out  DATA_WIDTH  shared read data, valid with any ch_data_ok
- sram_en  out  1  SRAM access this cycle
- sram_wen  out  WB  SRAM byte write enables
- sram_addr  out  ADDR_WIDTH  physical address to SRAM
- sram_wdata  out  DATA_WIDTH  SRAM write data
- sram_rdata  in  DATA_WIDTH  SRAM read data, valid the cycle after sram_en

## Operation
- State: rr_ptr (clog2(NUM_CH) bits), resp_vld (1 bit), resp_ch (clog2(NUM_CH) bits).
- Arbitration is combinational each cycle. The grant goes to the first channel with ch_req=1, searching from rr_ptr upward and wrapping modulo NUM_CH.
- On grant g: ch_addr_ok[g]=1, sram_en=1, and sram_wen/sram_addr/sram_wdata are driven from channel g.
- No request pending: sram_en=0, sram_wen=0, sram_addr=0, sram_wdata=0, all ch_addr_ok=0.
- Pointer update: on a grant, rr_ptr <= (g+1) mod NUM_CH. With no grant, rr_ptr holds.
- Response tracking: resp_vld <= grant_valid; resp_ch <= g.
- When resp_vld=1: ch_data_ok[resp_ch]=1 and ch_rdata=sram_rdata.
- When resp_vld=0: ch_data_ok=0 and ch_rdata=0.
- Writes also produce data_ok one cycle later; ch_rdata is don't-care for writes.
- Requesters always accept data_ok. There is no response backpressure.
- A channel may present its next request in the same cycle it receives data_ok.
- NUM_CH=1 degenerates to a pass-through with a one-cycle data_ok tracker; rr_ptr is constant 0.

## Timing
- Reset values: rr_ptr=0, resp_vld=0, resp_ch=0.
- During reset cycles and the cycle after reset deasserts, all ch_data_ok=0. Requests outstanding at reset are dropped with no data_ok.
- sram_en and ch_addr_ok are combinational from ch_req and rr_ptr in the same cycle. Requests may be accepted while reset is high, but their responses are discarded.
- Accept-to-response latency is exactly 1 cycle. Sustained throughput is 1 request/cycle across channels.
- Simultaneous requests from all channels: grants rotate strictly, with no channel starved longer than NUM_CH-1 cycles.
- A request deasserted before addr_ok is simply not served. The arbiter keeps no per-channel request state.
- Acceptance and a response to the same channel may occur in one cycle (back-to-back pipelining).

## Configuration
- Macro: SRAMX_RR_ARBITER_ADDR_XLAT_EN.
- Defined, with ADDR_WIDTH=32 required: sram_addr is the translated granted address.
  - Addresses in 0x8000_0000–0xBFFF_FFFF (kseg0/kseg1) have bits [31:29] cleared.
  - All other addresses pass unchanged.
- Undefined: sram_addr equals the granted ch_addr unmodified.
- Translation is combinational and adds no latency.

## Test plan
- Reset, then idle: hold reset 3 cycles and drive all ch_req=0.
  - Required: sram_en=0 and ch_addr_ok=0 throughout.
  - Required: ch_data_ok=0 in every cycle, including the first cycle after reset.
- Single read: ch0 reads address 0x0000_0100, with SRAM returning 0xDEAD_BEEF.
  - Cycle 0: ch_addr_ok=01, sram_addr=0x100, sram_wen=0.
  - Cycle 1: ch_data_ok=01, ch_rdata=0xDEAD_BEEF.
- Contention (NUM_CH=2): both channels hold ch_req=1 for 4 cycles.
  - Required: addr_ok sequence 01,10,01,10.
  - Required: data_ok the same sequence, delayed one cycle.
  - Required: rr_ptr=0 after the 4th grant.
- Translation: macro defined, ch1 writes 0xBFC0_0010, wen=1111, wdata=0x1234_5678.
  - Required: sram_addr=0x1FC0_0010, sram_wdata=0x1234_5678, ch_data_ok=10 one cycle later.
  - With the macro undefined: sram_addr=0xBFC0_0010.
  - Address 0x0000_0010 passes unchanged in both builds.
- Reset mid-operation: accept a ch0 read, then assert reset in the next cycle.
  - Required: no ch_data_ok for that read.
  - Required: after reset the first grant with both channels requesting goes to ch0.
- Back-to-back single channel: ch1 requests 3 consecutive cycles, addresses 0x0, 0x4, 0x8.
  - Required: addr_ok=10 in each of those cycles.
  - Required: data_ok=10 in the three following cycles, with rdata in address order.

Source files
------------

// File: rtl/sramx_rr_arbiter.sv
// ============================================================================
// Module   : sramx_rr_arbiter
// Purpose  : Round-robin N-channel SRAMx-style arbiter onto a single SRAM port
//            with one-cycle read latency and per-channel response routing.
// Options  : SRAMX_RR_ARBITER_ADDR_XLAT_EN enables kseg0/kseg1 stripping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sramx_rr_arbiter #(
   parameter int NUM_CH     = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_CH-1:0]              ch_req,
   input  logic [NUM_CH*(DATA_WIDTH/8)-1:0] ch_wen,
   input  logic [NUM_CH*ADDR_WIDTH-1:0]   ch_addr,
   input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_wdata,
   output logic [NUM_CH-1:0]              ch_addr_ok,
   output logic [NUM_CH-1:0]              ch_data_ok,
   output logic [DATA_WIDTH-1:0]          ch_rdata,
   output logic                           sram_en,
   output logic [DATA_WIDTH/8-1:0]        sram_wen,
   output logic [ADDR_WIDTH-1:0]          sram_addr,
   output logic [DATA_WIDTH-1:0]          sram_wdata,
   input  logic [DATA_WIDTH-1:0]          sram_rdata
);

   localparam int WB    = DATA_WIDTH / 8;
   localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic                  resp_vld_q, resp_vld_d;
   logic [PTR_W-1:0]      resp_ch_q, resp_ch_d;

   logic                  grant_vld;
   logic [PTR_W-1:0]      grant_idx;
   logic [WB-1:0]         sel_wen;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   // Descending scans leave the lowest matching index; channels at or above
   // the pointer override those below it, giving a wrapping search.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         if (ch_req[c] && (PTR_W'(c) < rr_ptr_q)) begin
            grant_vld = 1'b1;
            grant_idx = PTR_W'(c);
         end
      end
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         if (ch_req[c] && (PTR_W'(c) >= rr_ptr_q)) begin
            grant_vld = 1'b1;
            grant_idx = PTR_W'(c);
         end
      end
   end

   always_comb begin
      ch_addr_ok = '0;
      sel_wen    = '0;
      sel_addr   = '0;
      sel_wdata  = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (grant_vld && (grant_idx == PTR_W'(c))) begin
            ch_addr_ok[c] = 1'b1;
            sel_wen       = ch_wen[c*WB +: WB];
            sel_addr      = ch_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata     = ch_wdata[c*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign sram_en    = grant_vld;
   assign sram_wen   = sel_wen;
   assign sram_wdata = sel_wdata;

`ifdef SRAMX_RR_ARBITER_ADDR_XLAT_EN
   // kseg0/kseg1 (top bits 2'b10) map onto the low 512 MB physical window.
   always_comb begin
      sram_addr = sel_addr;
      if (sel_addr[ADDR_WIDTH-1 -: 2] == 2'b10) begin
         sram_addr[ADDR_WIDTH-1 -: 3] = 3'b000;
      end
   end
`else
   assign sram_addr = sel_addr;
`endif

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_vld) begin
         rr_ptr_d = (grant_idx == PTR_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
      end
      resp_vld_d = grant_vld;
      resp_ch_d  = grant_idx;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q   <= '0;
         resp_vld_q <= 1'b0;
         resp_ch_q  <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         resp_vld_q <= resp_vld_d;
         resp_ch_q  <= resp_ch_d;
      end
   end

   // Gating with reset drops a response whose request was accepted just
   // before reset asserted.
   always_comb begin
      ch_data_ok = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (resp_vld_q && !reset && (resp_ch_q == PTR_W'(c))) begin
            ch_data_ok[c] = 1'b1;
         end
      end
      ch_rdata = (resp_vld_q && !reset) ? sram_rdata : '0;
   end

endmodule

`default_nettype wire

// File: tb/tb_sramx_rr_arbiter.sv
// ============================================================================
// Module   : tb_sramx_rr_arbiter
// Purpose  : Directed scoreboard bench for sramx_rr_arbiter (NUM_CH=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sramx_rr_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  ch_req = '0;
   logic [7:0]  ch_wen = '0;
   logic [63:0] ch_addr = '0;
   logic [63:0] ch_wdata = '0;
   logic [1:0]  ch_addr_ok;
   logic [1:0]  ch_data_ok;
   logic [31:0] ch_rdata;
   logic        sram_en;
   logic [3:0]  sram_wen;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata = '0;

`ifdef SRAMX_RR_ARBITER_ADDR_XLAT_EN
   localparam logic [31:0] XLAT_BFC = 32'h1FC0_0010;
`else
   localparam logic [31:0] XLAT_BFC = 32'hBFC0_0010;
`endif

   typedef struct {
      logic [1:0]  ok;
      bit          chk;
      logic [31:0] rdata;
      int          cyc;
   } exp_t;

   exp_t        sb_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   logic [31:0] mem [0:255];

   sramx_rr_arbiter #(.NUM_CH(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .ch_req     (ch_req),
      .ch_wen     (ch_wen),
      .ch_addr    (ch_addr),
      .ch_wdata   (ch_wdata),
      .ch_addr_ok (ch_addr_ok),
      .ch_data_ok (ch_data_ok),
      .ch_rdata   (ch_rdata),
      .sram_en    (sram_en),
      .sram_wen   (sram_wen),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // One-cycle-latency SRAM with byte write enables.
   always @(posedge clk) begin
      if (sram_en) begin
         for (int b = 0; b < 4; b++) begin
            if (sram_wen[b]) mem[sram_addr[9:2]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
         end
         sram_rdata <= mem[sram_addr[9:2]];
      end else begin
         sram_rdata <= '0;
      end
   end

   // Response monitor: pops the scoreboard whenever any data_ok is seen.
   always @(negedge clk) begin
      exp_t e;
      if (ch_data_ok != 2'b00) begin
         n_tests++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL resp_unexpected: data_ok=%b rdata=%h cyc=%0d, required none", ch_data_ok, ch_rdata, cyc);
         end else begin
            e = sb_q.pop_front();
            if (e.cyc != cyc || e.ok != ch_data_ok || (e.chk && ch_rdata != e.rdata)) begin
               n_fail++;
               $display("FAIL resp: data_ok=%b rdata=%h cyc=%0d, required data_ok=%b rdata=%h cyc=%0d",
                        ch_data_ok, ch_rdata, cyc, e.ok, e.rdata, e.cyc);
            end
         end
      end else begin
         if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            n_tests++;
            n_fail++;
            e = sb_q.pop_front();
            $display("FAIL resp_missing: data_ok=%b cyc=%0d, required data_ok=%b", ch_data_ok, cyc, e.ok);
         end
         if (ch_rdata != 32'h0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rdata_idle: rdata=%h, required 00000000", ch_rdata);
         end
      end
   end

   task automatic set_ch(input int c, input logic req, input logic [3:0] wen,
                         input logic [31:0] addr, input logic [31:0] wdata);
      ch_req[c]             = req;
      ch_wen[c*4 +: 4]      = wen;
      ch_addr[c*32 +: 32]   = addr;
      ch_wdata[c*32 +: 32]  = wdata;
   endtask

   // Checks the request-phase outputs of the current cycle, optionally queues
   // the expected response for the next cycle, then advances one clock.
   task automatic step(input string name, input logic [1:0] e_aok, input logic [31:0] e_addr,
                       input logic [3:0] e_wen, input logic [31:0] e_wdata,
                       input bit push, input bit chk, input logic [31:0] e_rdata);
      exp_t e;
      @(negedge clk);
      n_tests++;
      if (ch_addr_ok !== e_aok || sram_en !== (|e_aok) || sram_addr !== e_addr ||
          sram_wen !== e_wen || sram_wdata !== e_wdata) begin
         n_fail++;
         $display("FAIL %s: aok=%b en=%b addr=%h wen=%h wdata=%h, required aok=%b en=%b addr=%h wen=%h wdata=%h",
                  name, ch_addr_ok, sram_en, sram_addr, sram_wen, sram_wdata,
                  e_aok, |e_aok, e_addr, e_wen, e_wdata);
      end
      if (push) begin
         e.ok    = e_aok;
         e.chk   = chk;
         e.rdata = e_rdata;
         e.cyc   = cyc + 1;
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[0]  = 32'h1111_1111;
      mem[1]  = 32'h2222_2222;
      mem[2]  = 32'h3333_3333;
      mem[64] = 32'hDEAD_BEEF;

      // Reset, then idle
      for (int i = 0; i < 3; i++) step("reset_idle", 2'b00, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0);
      reset = 1'b0;
      step("post_reset_idle", 2'b00, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0);

      // Contention: strict alternation from pointer 0
      set_ch(0, 1'b1, 4'h0, 32'h0000_0000, 32'h0);
      set_ch(1, 1'b1, 4'h0, 32'h0000_0004, 32'h0);
      step("cont0", 2'b01, 32'h0000_0000, 4'h0, 32'h0, 1, 1, 32'h1111_1111);
      step("cont1", 2'b10, 32'h0000_0004, 4'h0, 32'h0, 1, 1, 32'h2222_2222);
      step("cont2", 2'b01, 32'h0000_0000, 4'h0, 32'h0, 1, 1, 32'h1111_1111);
      step("cont3", 2'b10, 32'h0000_0004, 4'h0, 32'h0, 1, 1, 32'h2222_2222);
      step("cont_ptr0", 2'b01, 32'h0000_0000, 4'h0, 32'h0, 1, 1, 32'h1111_1111);

      // Idle with stale addresses on the inputs: outputs must be zero
      set_ch(0, 1'b0, 4'hF, 32'h0000_0100, 32'hAAAA_5555);
      set_ch(1, 1'b0, 4'h3, 32'h0000_0200, 32'h5555_AAAA);
      step("idle_zero", 2'b00, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0);

      // Single read on ch0 with pointer at 1 (wraps to ch0)
      set_ch(0, 1'b1, 4'h0, 32'h0000_0100, 32'h0);
      step("single_read", 2'b01, 32'h0000_0100, 4'h0, 32'h0, 1, 1, 32'hDEAD_BEEF);
      set_ch(0, 1'b0, 4'h0, 32'h0, 32'h0);

      // Write through kseg1 alias, then read back via the low alias
      set_ch(1, 1'b1, 4'hF, 32'hBFC0_0010, 32'h1234_5678);
      step("xlat_write", 2'b10, XLAT_BFC, 4'hF, 32'h1234_5678, 1, 0, 32'h0);
      set_ch(1, 1'b1, 4'h0, 32'h0000_0010, 32'h0);
      step("low_addr_pass", 2'b10, 32'h0000_0010, 4'h0, 32'h0, 1, 1, 32'h1234_5678);

      // Back-to-back on ch1
      set_ch(1, 1'b1, 4'h0, 32'h0000_0000, 32'h0);
      step("b2b0", 2'b10, 32'h0000_0000, 4'h0, 32'h0, 1, 1, 32'h1111_1111);
      set_ch(1, 1'b1, 4'h0, 32'h0000_0004, 32'h0);
      step("b2b1", 2'b10, 32'h0000_0004, 4'h0, 32'h0, 1, 1, 32'h2222_2222);
      set_ch(1, 1'b1, 4'h0, 32'h0000_0008, 32'h0);
      step("b2b2", 2'b10, 32'h0000_0008, 4'h0, 32'h0, 1, 1, 32'h3333_3333);
      set_ch(1, 1'b0, 4'h0, 32'h0, 32'h0);
      step("b2b_drain", 2'b00, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0);

      // Reset mid-operation: accepted read must never see data_ok
      set_ch(0, 1'b1, 4'h0, 32'h0000_0000, 32'h0);
      step("pre_reset_accept", 2'b01, 32'h0000_0000, 4'h0, 32'h0, 0, 0, 32'h0);
      set_ch(0, 1'b0, 4'h0, 32'h0, 32'h0);
      reset = 1'b1;
      step("mid_reset0", 2'b00, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0);
      step("mid_reset1", 2'b00, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0);
      reset = 1'b0;
      step("after_reset_idle", 2'b00, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0);
      set_ch(0, 1'b1, 4'h0, 32'h0000_0000, 32'h0);
      set_ch(1, 1'b1, 4'h0, 32'h0000_0004, 32'h0);
      step("after_reset_grant", 2'b01, 32'h0000_0000, 4'h0, 32'h0, 1, 1, 32'h1111_1111);
      set_ch(0, 1'b0, 4'h0, 32'h0, 32'h0);
      set_ch(1, 1'b0, 4'h0, 32'h0, 32'h0);
      step("final_idle", 2'b00, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0);
      step("final_idle2", 2'b00, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0);

      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: %0d responses outstanding, required 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
